// File: rtl/tron_round_ctrl.sv
// Match sequencer for the two-player light-cycle game: round flow, movement tick,
// heading arbitration and scorekeeping.
module tron_round_ctrl #(
    parameter int TICK_DIV    = 2097152,
    parameter int WIN_SCORE   = 10,
    parameter int PAUSE_TICKS = 32
) (
    input  logic       board_clk,
    input  logic       reset,
    input  logic       start,
    input  logic       p1_req_valid,
    input  logic [1:0] p1_req_dir,
    input  logic       p2_req_valid,
    input  logic [1:0] p2_req_dir,
    input  logic       crash_valid,
    input  logic       p1_crash,
    input  logic       p2_crash,
    input  logic       clear_done,
    output logic [2:0] state,
    output logic       move_tick,
    output logic [1:0] p1_dir,
    output logic [1:0] p2_dir,
    output logic       clear_req,
    output logic [3:0] p1_score,
    output logic [3:0] p2_score,
    output logic [1:0] last_result,
    output logic [1:0] winner
);
    typedef enum logic [2:0] {
        IDLE = 3'b000, CLEAR = 3'b001, PLAY = 3'b010, ROUND_END = 3'b011, DONE = 3'b100
    } state_t;

    localparam int TW = $clog2(TICK_DIV);
    localparam int PW = $clog2(PAUSE_TICKS) + 1;
    localparam logic [TW-1:0] TickMax  = TW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PauseMax = PW'(PAUSE_TICKS - 1);
    localparam logic [3:0]    Win      = 4'(WIN_SCORE);
    localparam logic [1:0][1:0] InitDir = {2'b11, 2'b01};

    state_t st, nextSt;
    logic startMeta, startS, startPrev, startRise;
    logic [TW-1:0] tickCnt;
    logic [PW-1:0] pauseCnt;
    logic tickWrap, pauseDone, anyCrash, running;

    assign startRise = startS & ~startPrev;
    assign tickWrap  = (tickCnt == TickMax);
    assign pauseDone = (st == ROUND_END) && tickWrap && (pauseCnt == PauseMax);
    assign anyCrash  = crash_valid && (p1_crash || p2_crash);
    assign running   = (st == CLEAR) || (st == PLAY) || (st == ROUND_END);

    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            startMeta <= 1'b0;
            startS    <= 1'b0;
            startPrev <= 1'b0;
        end else begin
            startMeta <= start;
            startS    <= startMeta;
            startPrev <= startS;
        end
    end

    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) st <= IDLE;
        else       st <= nextSt;
    end

    // Dropping the switch aborts from any active state before anything else is considered.
    always_comb begin
        nextSt = st;
        case (st)
            IDLE:      if (startRise) nextSt = CLEAR;
            CLEAR:     if (!startS) nextSt = IDLE;
                       else if (clear_done) nextSt = PLAY;
            PLAY:      if (!startS) nextSt = IDLE;
                       else if (anyCrash) nextSt = ROUND_END;
            ROUND_END: if (!startS) nextSt = IDLE;
                       else if (pauseDone)
                           nextSt = (p1_score == Win || p2_score == Win) ? DONE : CLEAR;
            DONE:      if (!startS) nextSt = IDLE;
            default:   nextSt = IDLE;
        endcase
    end

    always_comb begin
        state     = st;
        move_tick = (st == PLAY) && tickWrap;
    end

    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            tickCnt   <= '0;
            pauseCnt  <= '0;
            clear_req <= 1'b0;
        end else begin
            clear_req <= (nextSt == CLEAR);
            if (st == PLAY || st == ROUND_END) tickCnt <= tickWrap ? '0 : tickCnt + TW'(1);
            else                               tickCnt <= '0;
            if (st != ROUND_END || pauseDone) pauseCnt <= '0;
            else if (tickWrap)                pauseCnt <= pauseCnt + PW'(1);
        end
    end

    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            p1_score    <= '0;
            p2_score    <= '0;
            last_result <= 2'b00;
            winner      <= 2'b00;
        end else begin
            if (st == IDLE && startRise) begin
                p1_score    <= '0;
                p2_score    <= '0;
                last_result <= 2'b00;
                winner      <= 2'b00;
            end
            if (st == PLAY && startS && crash_valid) begin
                case ({p1_crash, p2_crash})
                    2'b10: begin
                        if (p2_score != Win) p2_score <= p2_score + 4'd1;
                        last_result <= 2'b10;
                    end
                    2'b01: begin
                        if (p1_score != Win) p1_score <= p1_score + 4'd1;
                        last_result <= 2'b01;
                    end
                    2'b11:   last_result <= 2'b11;
                    default: ;
                endcase
            end
            if (startS && pauseDone) begin
                if (p1_score == Win)      winner <= 2'b01;
                else if (p2_score == Win) winner <= 2'b10;
            end
            if (running && !startS) winner <= 2'b00;
        end
    end

    // Per-player heading arbitration; a request landing on a tick stays pending for the next one.
    logic [1:0][1:0] reqDir, pendDir, dirR;
    logic [1:0]      reqValid, pendValid;
    assign reqValid = {p2_req_valid, p1_req_valid};
    assign reqDir   = {p2_req_dir, p1_req_dir};
    assign p1_dir   = dirR[0];
    assign p2_dir   = dirR[1];

    for (genvar i = 0; i < 2; i++) begin : gPlayer
        always_ff @(posedge board_clk or posedge reset) begin
            if (reset) begin
                dirR[i]      <= InitDir[i];
                pendDir[i]   <= 2'b00;
                pendValid[i] <= 1'b0;
            end else if (st == CLEAR) begin
                dirR[i]      <= InitDir[i];
                pendValid[i] <= 1'b0;
            end else if (st == PLAY) begin
                if (move_tick && pendValid[i] && pendDir[i] != (dirR[i] ^ 2'b10))
                    dirR[i] <= pendDir[i];
                if (reqValid[i]) begin
                    pendDir[i]   <= reqDir[i];
                    pendValid[i] <= 1'b1;
                end else if (move_tick) begin
                    pendValid[i] <= 1'b0;
                end
            end else begin
                pendValid[i] <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_tron_round_ctrl.sv
// Directed bench for tron_round_ctrl: match flow, tick timing, heading arbitration, scoring, aborts.
module tb_tron_round_ctrl;
    logic       board_clk = 1'b0;
    logic       reset = 1'b1, start = 1'b0;
    logic       p1_req_valid = 1'b0, p2_req_valid = 1'b0;
    logic [1:0] p1_req_dir = 2'b00, p2_req_dir = 2'b00;
    logic       crash_valid = 1'b0, p1_crash = 1'b0, p2_crash = 1'b0, clear_done = 1'b0;
    logic [2:0] state;
    logic       move_tick, clear_req;
    logic [1:0] p1_dir, p2_dir, last_result, winner;
    logic [3:0] p1_score, p2_score;

    typedef struct { logic [3:0] s1; logic [3:0] s2; logic [1:0] lr; } res_t;
    res_t       resQ[$];
    logic [1:0] p1Q[$], p2Q[$];
    int checks = 0, failures = 0, tickCount = 0;

    tron_round_ctrl #(.TICK_DIV(8), .WIN_SCORE(2), .PAUSE_TICKS(2)) dut (
        .board_clk(board_clk), .reset(reset), .start(start),
        .p1_req_valid(p1_req_valid), .p1_req_dir(p1_req_dir),
        .p2_req_valid(p2_req_valid), .p2_req_dir(p2_req_dir),
        .crash_valid(crash_valid), .p1_crash(p1_crash), .p2_crash(p2_crash),
        .clear_done(clear_done), .state(state), .move_tick(move_tick),
        .p1_dir(p1_dir), .p2_dir(p2_dir), .clear_req(clear_req),
        .p1_score(p1_score), .p2_score(p2_score),
        .last_result(last_result), .winner(winner)
    );

    always #5 board_clk = ~board_clk;
    always @(negedge board_clk) if (move_tick === 1'b1) tickCount++;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge board_clk);
        #1;
    endtask

    task automatic waitTick(output int n);
        n = 0;
        do begin step(1); n++; end while (move_tick !== 1'b1 && n < 64);
        chk("tick_seen", {7'd0, move_tick}, 8'd1);
    endtask

    task automatic waitState(input string tag, input logic [2:0] exp);
        int n = 0;
        while (state !== exp && n < 40) begin step(1); n++; end
        chk(tag, {5'd0, state}, {5'd0, exp});
    endtask

    task automatic popRes(input string tag);
        res_t r = resQ.pop_front();
        chk({tag, "_p1score"}, {4'd0, p1_score}, {4'd0, r.s1});
        chk({tag, "_p2score"}, {4'd0, p2_score}, {4'd0, r.s2});
        chk({tag, "_result"}, {6'd0, last_result}, {6'd0, r.lr});
    endtask

    // ROUND_END must last exactly two tick periods and issue no tick.
    task automatic pauseCheck(input string tag, input logic [2:0] nxt);
        int n = 0;
        int t0 = tickCount;
        while (state === 3'b011 && n < 100) begin n++; step(1); end
        chk({tag, "_len"}, 8'(n), 8'd16);
        chk({tag, "_noTick"}, 8'(tickCount - t0), 8'd0);
        chk({tag, "_next"}, {5'd0, state}, {5'd0, nxt});
    endtask

    task automatic crashAtTick(input logic c1, input logic c2, input res_t exp);
        int n;
        waitTick(n);
        crash_valid = 1'b1; p1_crash = c1; p2_crash = c2;
        resQ.push_back(exp);
        step(1);
        crash_valid = 1'b0; p1_crash = 1'b0; p2_crash = 1'b0;
        chk("crash_state", {5'd0, state}, 8'd3);
        popRes("crash");
    endtask

    task automatic enterPlay();
        clear_done = 1'b1;
        step(1);
        clear_done = 1'b0;
        chk("play_entry", {5'd0, state}, 8'd2);
        chk("play_p1dir", {6'd0, p1_dir}, 8'd1);
        chk("play_p2dir", {6'd0, p2_dir}, 8'd3);
    endtask

    initial begin
        int n, cnt, t0;
        step(3);
        chk("rst_state", {5'd0, state}, 8'd0);
        chk("rst_tick", {7'd0, move_tick}, 8'd0);
        chk("rst_clear", {7'd0, clear_req}, 8'd0);
        chk("rst_dirs", {4'd0, p1_dir, p2_dir}, 8'h07);
        chk("rst_scores", {p1_score, p2_score}, 8'h00);
        chk("rst_res_win", {4'd0, last_result, winner}, 8'h00);
        reset = 1'b0;
        step(2);

        start = 1'b1;
        waitState("to_clear", 3'b001);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (clear_req === 1'b1) cnt++;
            if (i == 4) clear_done = 1'b1;
            step(1);
        end
        clear_done = 1'b0;
        chk("clear_req_len", 8'(cnt), 8'd5);
        chk("clear_req_drop", {7'd0, clear_req}, 8'd0);
        chk("play_state", {5'd0, state}, 8'd2);
        waitTick(n);
        chk("first_tick", 8'(n + 1), 8'd8);
        waitTick(n);
        chk("tick_period", 8'(n), 8'd8);

        // latest request wins; commit only after the tick
        step(1);
        p1_req_valid = 1'b1; p1_req_dir = 2'b00; p2_req_valid = 1'b1; p2_req_dir = 2'b10;
        step(1);
        p1_req_dir = 2'b10; p2_req_valid = 1'b0;
        step(1);
        p1_req_valid = 1'b0;
        p1Q.push_back(2'b10); p2Q.push_back(2'b10);
        waitTick(n);
        chk("no_early_commit", {6'd0, p1_dir}, 8'd1);
        step(1);
        chk("p1_commit", {6'd0, p1_dir}, {6'd0, p1Q.pop_front()});
        chk("p2_commit", {6'd0, p2_dir}, {6'd0, p2Q.pop_front()});

        p1_req_valid = 1'b1; p1_req_dir = 2'b00;
        step(1);
        p1_req_valid = 1'b0;
        p1Q.push_back(2'b10);
        waitTick(n);
        step(1);
        chk("reversal_drop", {6'd0, p1_dir}, {6'd0, p1Q.pop_front()});

        waitTick(n);
        p1_req_valid = 1'b1; p1_req_dir = 2'b01;
        step(1);
        p1_req_valid = 1'b0;
        chk("tick_req_held", {6'd0, p1_dir}, 8'd2);
        p1Q.push_back(2'b01);
        waitTick(n);
        step(1);
        chk("tick_req_commit", {6'd0, p1_dir}, {6'd0, p1Q.pop_front()});

        crashAtTick(1'b0, 1'b1, '{4'd1, 4'd0, 2'b01});
        pauseCheck("pause1", 3'b001);

        enterPlay();
        crash_valid = 1'b1;
        step(1);
        crash_valid = 1'b0;
        chk("nocrash_stay", {5'd0, state}, 8'd2);
        crashAtTick(1'b1, 1'b1, '{4'd1, 4'd0, 2'b11});
        pauseCheck("pause2", 3'b001);

        enterPlay();
        crashAtTick(1'b0, 1'b1, '{4'd2, 4'd0, 2'b01});
        pauseCheck("pause3", 3'b100);
        chk("winner_p1", {6'd0, winner}, 8'd1);
        step(3);
        chk("done_hold", {5'd0, state}, 8'd4);

        start = 1'b0;
        waitState("done_to_idle", 3'b000);
        start = 1'b1;
        waitState("restart_clear", 3'b001);
        chk("restart_scores", {p1_score, p2_score}, 8'h00);
        chk("restart_res_win", {4'd0, last_result, winner}, 8'h00);

        enterPlay();
        crashAtTick(1'b1, 1'b0, '{4'd0, 4'd1, 2'b10});
        pauseCheck("pause4", 3'b001);
        enterPlay();
        step(2);
        t0 = tickCount;
        start = 1'b0;
        waitState("abort_idle", 3'b000);
        step(8);
        chk("abort_noTick", 8'(tickCount - t0), 8'd0);
        chk("abort_score", {4'd0, p2_score}, 8'd1);
        chk("abort_winner", {6'd0, winner}, 8'd0);
        chk("abort_clear", {7'd0, clear_req}, 8'd0);

        start = 1'b1;
        waitState("rst_mid_clear", 3'b001);
        clear_done = 1'b1;
        #2 reset = 1'b1;
        #1;
        chk("async_state", {5'd0, state}, 8'd0);
        chk("async_clear", {7'd0, clear_req}, 8'd0);
        chk("async_dirs", {4'd0, p1_dir, p2_dir}, 8'h07);
        chk("async_outs", {p1_score, p2_score}, 8'h00);
        clear_done = 1'b0;
        step(2);
        chk("held_in_reset", {5'd0, state}, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tron_round_ctrl.md
Name: tron_round_ctrl

Overview:
Game sequencer for the two-player light-cycle datapath. It runs the match flow: idle, arena clear, play, round end, match done. It generates the movement tick, arbitrates each player's direction request into a committed heading, consumes crash reports from the collision datapath, and keeps per-player scores. Its outputs feed the position/trail datapath, the status LEDs and the 7-segment score display.

Parameters:
TICK_DIV, 2097152, board_clk cycles per movement step (must be >= 4)
WIN_SCORE, 10, round wins needed to take the match (1..15)
PAUSE_TICKS, 32, tick periods spent in ROUND_END before the next round

Ports:
board_clk  in  1  system clock
reset  in  1  asynchronous, active-high
start  in  1  start switch level, asynchronous; 2-FF synchronized internally
p1_req_valid  in  1  one-cycle pulse: P1 direction request
p1_req_dir  in  2  requested heading (00 up, 01 right, 10 down, 11 left)
p2_req_valid  in  1  one-cycle pulse: P2 direction request
p2_req_dir  in  2  P2 requested heading
crash_valid  in  1  one-cycle pulse: datapath finished evaluating the last step
p1_crash  in  1  P1 hit a wall or trail; qualified by crash_valid
p2_crash  in  1  P2 hit a wall or trail; qualified by crash_valid
clear_done  in  1  datapath finished clearing the arena
state  out  3  000 IDLE, 001 CLEAR, 010 PLAY, 011 ROUND_END, 100 DONE
move_tick  out  1  one-cycle step strobe, asserted only in PLAY
p1_dir  out  2  committed P1 heading
p2_dir  out  2  committed P2 heading
clear_req  out  1  arena clear/position reload request
p1_score  out  4  P1 round wins
p2_score  out  4  P2 round wins
last_result  out  2  00 none, 01 P1 won round, 10 P2 won round, 11 draw
winner  out  2  00 none, 01 P1, 10 P2; valid in DONE

Behaviour:
- Reset (async): state=IDLE; move_tick=0; clear_req=0; p1_dir=01; p2_dir=11; scores=0; last_result=00; winner=00; pending requests cleared; tick and pause counters=0.
- start_s is the synchronized start signal. start_rise is start_s high with its previous value low.
- IDLE: on start_rise, zero both scores, set last_result=00 and winner=00, then go to CLEAR.
- CLEAR:
  - clear_req=1. It is a registered output, high from the first CLEAR cycle.
  - p1_dir is loaded with 01 and p2_dir with 11.
  - Pending requests are discarded.
  - Stay in CLEAR until clear_done=1 is sampled. In that cycle clear_req drops, the tick counter is zeroed, and the next state is PLAY.
- PLAY, tick counter:
  - Counts 0..TICK_DIV-1 and wraps.
  - move_tick=1 in the cycle the counter equals TICK_DIV-1.
  - The first tick occurs TICK_DIV cycles after entering PLAY.
- PLAY, direction requests:
  - A req_valid pulse stores req_dir in that player's pending register. The latest request wins; a request arriving in the same cycle as an older pending one overwrites it.
  - On a move_tick cycle, a pending request is committed to pX_dir. The new dir is visible the cycle after move_tick, i.e. from the next step onward. The pending register is then cleared.
  - A reversal (req_dir == pX_dir XOR 2'b10) is dropped at commit and pX_dir is unchanged.
  - A request arriving in the same cycle as move_tick is held pending for the following tick.
  - Requests outside PLAY are ignored.
- PLAY, crash reports:
  - crash_valid with neither crash bit set: stay in PLAY.
  - Only p1_crash: p2_score+1, last_result=10.
  - Only p2_crash: p1_score+1, last_result=01.
  - Both: draw, last_result=11, no score change.
  - Any crash goes to ROUND_END. Scores saturate at WIN_SCORE.
- crash_valid outside PLAY is ignored.
- ROUND_END:
  - No move_tick is issued. The tick counter keeps running, and the pause counter counts its wraps.
  - After PAUSE_TICKS wraps: if either score equals WIN_SCORE, set winner accordingly and go to DONE; otherwise go to CLEAR.
- DONE: hold scores and winner. When start_s=0, go to IDLE.
- Switch dropped mid-game: if start_s=0 in CLEAR, PLAY or ROUND_END, go to IDLE. This aborts the match: clear_req=0, scores are retained, winner=00.
- Reset mid-operation: immediate return to the reset values above, regardless of state or handshake.

Test Plan:
- TICK_DIV=8, PAUSE_TICKS=2, WIN_SCORE=2. Sequence: reset, start rises, clear_done after 5 cycles -> clear_req high for exactly those cycles; state=PLAY; first move_tick 8 cycles later, then every 8 cycles; dirs 01/11.
- In PLAY, p1 request 00 then 10 within one tick period -> p1_dir=10 after next tick. Then request 00 (reversal) -> p1_dir stays 10. A request in a move_tick cycle commits one tick later.
- crash_valid with p2_crash=1 -> p1_score=1, last_result=01, ROUND_END for 16 cycles with no move_tick, then CLEAR.
- crash_valid with both crash bits -> last_result=11, scores unchanged.
- Second p1 win -> p1_score=2, winner=01, DONE. start low -> IDLE. Start again -> scores 0.
- Two aborts:
  - start low during PLAY -> IDLE next cycles, no move_tick.
  - reset asserted during CLEAR with clear_done pending -> all outputs at reset values immediately.
